instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Reads the instruction memory that the testbench writes through the Microprocessor_intf interface.
//  Maintains pc and fetches instructions.
//  Resolves JMP and JZ locally.
//  Issues ADD/SUB to the execute stage over a valid/ready handshake.
//  Sits between the instruction array and the ALU/accumulator stage; pc goes to the interface.
// PARAMETERS
//  ADDR_WIDTH  6                instruction address width; also the operand field width
//  DATA_WIDTH  8                instruction width; equals 2 + ADDR_WIDTH
//  MEM_SIZE    2**ADDR_WIDTH    number of instruction words
//  CNT_WIDTH   16               width of the retired-instruction counter
// PORTS
//  clk           in   1           clock, rising edge
//  rst           in   1           synchronous, active-high reset
//  instructions  in   DATA_WIDTH x MEM_SIZE   instruction array, read combinationally at pc
//  pc            out  ADDR_WIDTH  current program counter
//  op_valid      out  1           an ALU op is presented
//  op_code       out  1           0 = ADD, 1 = SUB; valid when op_valid
//  op_addr       out  ADDR_WIDTH  operand address; valid when op_valid
//  op_ready      in   1           execute stage accepts the op
//  exec_busy     in   1           execute stage holds an op not yet retired; zero_flag is stale
//  zero_flag     in   1           flag from the last retired ALU op
//  halted        out  1           self-jump detected; the unit is frozen
//  instr_count   out  CNT_WIDTH   instructions completed, saturating
// BEHAVIOUR
//  Encoding: ir[7:6] = opcode, ir[5:0] = addr.
//   - 00 ADD
//   - 01 SUB
//   - 10 JMP
//   - 11 JZ
//  FSM states: FETCH, DECODE, ISSUE, WAIT_FLAG, HALT.
//  Reset values, applied on any clk edge with rst=1, including mid-operation:
//   - state = FETCH
//   - pc = 0, ir = 0
//   - op_valid = 0, halted = 0, instr_count = 0
//   - an op in flight is dropped without handshake
//  FETCH: ir <= instructions[pc]; go to DECODE.
//  DECODE, by opcode:
//   - ADD/SUB: go to ISSUE.
//   - JMP, addr != pc: pc <= addr; go to FETCH.
//   - JMP, addr == pc: go to HALT; pc is unchanged.
//   - JZ, exec_busy = 1: go to WAIT_FLAG.
//   - JZ, exec_busy = 0: pc <= zero_flag ? addr : pc+1; go to FETCH.
//  ISSUE:
//   - op_valid = 1; op_code and op_addr are registered from ir and held stable until the handshake.
//   - On op_valid & op_ready: pc <= pc+1; go to FETCH; op_valid drops the next cycle.
//   - If op_ready = 0, stay in ISSUE; a stall has no length limit.
//  WAIT_FLAG: stay until exec_busy = 0, then resolve as in DECODE JZ in that same cycle.
//  HALT:
//   - halted = 1 and op_valid = 0.
//   - pc stays frozen until rst.
//   - A JZ whose taken target equals pc does not halt.
//  Latency from entering FETCH:
//   - ALU op: op_valid asserts 2 cycles later.
//   - JMP: new pc visible 2 cycles later.
//   - JZ with exec_busy = 0: new pc visible 2 cycles later.
//  Arithmetic:
//   - pc+1 is modulo MEM_SIZE: pc 63 becomes 0.
//   - instr_count increments once per completed instruction: on ALU handshake, JMP resolve, JZ resolve.
//   - instr_count saturates at all-ones; HALT does not count.
//  Simultaneous events: a handshake in ISSUE and exec_busy changing in the same cycle have no
//  interaction; exec_busy is sampled only in DECODE and WAIT_FLAG.
// STRUCTURE
//  uproc_pkg holds:
//   - opcode_e {OP_ADD, OP_SUB, OP_JMP, OP_JZ}
//   - fetch_state_e
//   - localparams OPC_MSB / OPC_LSB
//   - function decode_instr(ir), returning {opcode, addr}
//  No sub-module: one FSM plus pc/ir/counter registers, about 150 lines.
// TESTING
//  1 reset: rst=1 for 2 cycles with instructions[0]=8'h05
//    -> pc=0, op_valid=0, halted=0, instr_count=0.
//    After release: op_valid=1, op_code=0, op_addr=5 on the 3rd edge.
//  2 stall: ADD 5 issued with op_ready=0 for 4 cycles
//    -> op_valid, op_code and op_addr held constant; pc stays 0.
//    op_ready=1 -> pc=1 the next cycle; instr_count=1.
//  3 jump: mem[0]=8'h8A (JMP 10), mem[10]=8'h8A (JMP 10)
//    -> pc=10, then halted=1 with pc=10 and instr_count=1.
//    Applying rst then restarts at pc=0.
//  4 JZ with flag: mem[0]=8'hD4 (JZ 20), exec_busy=1 for 3 cycles, then 0 with zero_flag=1
//    -> pc=20.
//    Repeat with zero_flag=0 -> pc=1.
//  5 wrap: mem[63]=8'h41 (SUB 1), handshake accepted
//    -> pc=0; the next fetch reads mem[0].
//  6 mid-op reset: rst=1 while in ISSUE
//    -> op_valid=0 on the next edge; pc=0; no op_ready response is required.

Source files
------------

// File: rtl/uproc_pkg.sv
// Shared types for the micro-processor fetch path: opcode and FSM state encodings
// plus the instruction-word decode helper.
package uproc_pkg;

   localparam int ADDR_W  = 6;
   localparam int DATA_W  = 2 + ADDR_W;
   localparam int OPC_MSB = DATA_W - 1;
   localparam int OPC_LSB = DATA_W - 2;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_JMP = 2'b10,
      OP_JZ  = 2'b11
   } opcode_e;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_ISSUE,
      ST_WAIT_FLAG,
      ST_HALT
   } fetch_state_e;

   typedef struct packed {
      opcode_e             opcode;
      logic [ADDR_W-1:0]   addr;
   } decoded_t;

   function automatic decoded_t decode_instr(input logic [DATA_W-1:0] ir);
      decoded_t d;
      d.opcode = opcode_e'(ir[OPC_MSB:OPC_LSB]);
      d.addr   = ir[ADDR_W-1:0];
      return d;
   endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch/decode front end: walks the instruction array, resolves JMP/JZ locally and
// hands ADD/SUB to the execute stage with a valid/ready handshake.
module instr_fetch_unit
   import uproc_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_W,
   parameter int DATA_WIDTH = DATA_W,
   parameter int MEM_SIZE   = 2**ADDR_WIDTH,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] instructions [MEM_SIZE],
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  op_valid,
   output logic                  op_code,
   output logic [ADDR_WIDTH-1:0] op_addr,
   input  logic                  op_ready,
   input  logic                  exec_busy,
   input  logic                  zero_flag,
   output logic                  halted,
   output logic [CNT_WIDTH-1:0]  instr_count,
   output fetch_state_e          dbg_state
);

   // Handshake: an op transfers on any rising edge where op_valid and op_ready are
   // both high; op_code/op_addr stay stable while op_valid is high and op_ready low.

   fetch_state_e            r_state;
   fetch_state_e            w_state_next;
   logic [ADDR_WIDTH-1:0]   r_pc;
   logic [ADDR_WIDTH-1:0]   w_pc_next;
   logic [ADDR_WIDTH-1:0]   w_pc_inc;
   logic [ADDR_WIDTH-1:0]   w_jz_pc;
   logic [DATA_WIDTH-1:0]   r_ir;
   logic                    r_op_code;
   logic [ADDR_WIDTH-1:0]   r_op_addr;
   logic [CNT_WIDTH-1:0]    r_count;
   logic                    w_retire;
   decoded_t                w_dec;

   assign w_dec    = decode_instr(r_ir);
   assign w_pc_inc = r_pc + 1'b1;
   assign w_jz_pc  = zero_flag ? w_dec.addr : w_pc_inc;

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_retire     = 1'b0;
      case (r_state)
         ST_FETCH: w_state_next = ST_DECODE;
         ST_DECODE: begin
            case (w_dec.opcode)
               OP_ADD, OP_SUB: w_state_next = ST_ISSUE;
               OP_JMP: begin
                  if (w_dec.addr == r_pc) begin
                     w_state_next = ST_HALT;
                  end else begin
                     w_pc_next    = w_dec.addr;
                     w_retire     = 1'b1;
                     w_state_next = ST_FETCH;
                  end
               end
               OP_JZ: begin
                  if (exec_busy) begin
                     w_state_next = ST_WAIT_FLAG;
                  end else begin
                     w_pc_next    = w_jz_pc;
                     w_retire     = 1'b1;
                     w_state_next = ST_FETCH;
                  end
               end
               default: w_state_next = ST_FETCH;
            endcase
         end
         ST_ISSUE: begin
            if (op_ready) begin
               w_pc_next    = w_pc_inc;
               w_retire     = 1'b1;
               w_state_next = ST_FETCH;
            end
         end
         ST_WAIT_FLAG: begin
            if (!exec_busy) begin
               w_pc_next    = w_jz_pc;
               w_retire     = 1'b1;
               w_state_next = ST_FETCH;
            end
         end
         ST_HALT: w_state_next = ST_HALT;
         default: w_state_next = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_FETCH;
         r_pc      <= '0;
         r_ir      <= '0;
         r_op_code <= 1'b0;
         r_op_addr <= '0;
         r_count   <= '0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         if (r_state == ST_FETCH) begin
            r_ir <= instructions[r_pc];
         end
         // Operand fields are captured on the way into ISSUE so they cannot move during a stall.
         if (r_state == ST_DECODE) begin
            r_op_code <= (w_dec.opcode == OP_SUB);
            r_op_addr <= w_dec.addr;
         end
         if (w_retire && (r_count != {CNT_WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign pc          = r_pc;
   assign op_valid    = (r_state == ST_ISSUE);
   assign op_code     = r_op_code;
   assign op_addr     = r_op_addr;
   assign halted      = (r_state == ST_HALT);
   assign instr_count = r_count;
   assign dbg_state   = r_state;

endmodule
